// File: rtl/image_buffer_reader.sv
// Reader side of the image buffer: snapshots the packed image, then streams it out one byte per valid/ready beat.
// Define IMG_READER_CHECKSUM_EN to append one XOR checksum beat after the last image byte.
module image_buffer_reader #(
  parameter int TOTAL_BITS = 904,
  parameter int BYTE_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  img_valid,
  input  logic [TOTAL_BITS-1:0] img_in,
  output logic [BYTE_W-1:0]     data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [9:0]            read_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int         NUM_BYTES = TOTAL_BITS / BYTE_W;
  localparam logic [9:0] LAST_PTR  = 10'((NUM_BYTES - 1) * BYTE_W);
  localparam logic [9:0] STEP      = 10'(BYTE_W);

`ifdef IMG_READER_CHECKSUM_EN
  localparam logic [9:0] END_PTR = 10'(TOTAL_BITS);
  typedef enum logic [1:0] {IDLE, STREAM, CSUM, DONE} state_t;
`else
  localparam logic [9:0] END_PTR = 10'd0;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
`endif

  state_t                state, state_next;
  logic [TOTAL_BITS-1:0] shadow;
  logic [9:0]            ptr;
  logic [BYTE_W-1:0]     cur_byte;
  logic                  capture;
  logic                  stream_beat;

  // abort outranks a start seen in the same cycle, so a dropped start never captures.
  assign capture     = (state == IDLE) && start && img_valid && !abort;
  assign stream_beat = (state == STREAM) && data_ready && !abort;
  assign cur_byte    = shadow[ptr +: BYTE_W];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; data_valid is always high in STREAM/CSUM, so data_ready alone marks a handshake.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && img_valid) state_next = STREAM;
`ifdef IMG_READER_CHECKSUM_EN
        STREAM:  if (data_ready && ptr == LAST_PTR) state_next = CSUM;
        CSUM:    if (data_ready) state_next = DONE;
`else
        STREAM:  if (data_ready && ptr == LAST_PTR) state_next = DONE;
`endif
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef IMG_READER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           csum <= '0;
    else if (capture)     csum <= '0;
    else if (stream_beat) csum <= csum ^ cur_byte;
  end
`endif

  // Outputs decode the registered state only.
  // NOTE: every output gets a default before the case, otherwise the comb block infers latches.
  always_comb begin
    data_out   = '0;
    data_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      STREAM: begin
        data_out   = cur_byte;
        data_valid = 1'b1;
        busy       = 1'b1;
      end
`ifdef IMG_READER_CHECKSUM_EN
      CSUM: begin
        data_out   = csum;
        data_valid = 1'b1;
        busy       = 1'b1;
      end
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign read_addr = ptr;

  // NOTE: the snapshot is pure datapath and deliberately unreset; data_out only exposes it in STREAM.
  always_ff @(posedge clk) begin
    if (capture) shadow <= img_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      error <= 1'b0;
    end else begin
      error <= (state == IDLE) && start && !img_valid && !abort;
      if (abort || capture || state == DONE)
        ptr <= '0;
      else if (stream_beat)
        ptr <= (ptr == LAST_PTR) ? END_PTR : ptr + STEP;
`ifdef IMG_READER_CHECKSUM_EN
      else if (state == CSUM && data_ready)
        ptr <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_image_buffer_reader.sv
// Self-checking bench for image_buffer_reader: scoreboard of expected {byte, addr} beats popped on each handshake.
// Honours IMG_READER_CHECKSUM_EN to expect the extra checksum beat.
module tb_image_buffer_reader;

  localparam int TOTAL_BITS = 904;
  localparam int BYTE_W     = 8;
  localparam int NUM_BYTES  = TOTAL_BITS / BYTE_W;
`ifdef IMG_READER_CHECKSUM_EN
  localparam int BEATS = NUM_BYTES + 1;
`else
  localparam int BEATS = NUM_BYTES;
`endif

  logic                  clk        = 1'b0;
  logic                  rst_n      = 1'b1;
  logic                  start      = 1'b0;
  logic                  abort      = 1'b0;
  logic                  img_valid  = 1'b0;
  logic                  data_ready = 1'b0;
  logic [TOTAL_BITS-1:0] img_in     = '0;
  logic [BYTE_W-1:0]     data_out;
  logic                  data_valid;
  logic [9:0]            read_addr;
  logic                  busy;
  logic                  done;
  logic                  error;

  logic [TOTAL_BITS-1:0] ref_img;
  logic [17:0]           sb[$];
  int                    n_checks = 0;
  int                    n_pass   = 0;

  always #5 clk = ~clk;

  image_buffer_reader #(.TOTAL_BITS(TOTAL_BITS), .BYTE_W(BYTE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .img_valid  (img_valid),
    .img_in     (img_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .read_addr  (read_addr),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Expected beats come from the bench's own image model, pushed before the stream starts.
  task automatic push_expected();
`ifdef IMG_READER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
`endif
    sb.delete();
    for (int k = 0; k < NUM_BYTES; k++) begin
      sb.push_back({ref_img[k*8 +: 8], 10'(k * 8)});
`ifdef IMG_READER_CHECKSUM_EN
      x ^= ref_img[k*8 +: 8];
`endif
    end
`ifdef IMG_READER_CHECKSUM_EN
    sb.push_back({x, 10'(TOTAL_BITS)});
`endif
  endtask

  // stall: ready pattern 1,0,0,1,0; abort_at: abort on the handshake with that index;
  // mutate_at: overwrite img_in with all ones once that many bytes have transferred.
  task automatic run_stream(input bit stall, input int abort_at, input int mutate_at, input bit hold_start);
    int          hs       = 0;
    bit          stalled  = 1'b0;
    bit          prev_hs  = 1'b0;
    bit          finished = 1'b0;
    logic [4:0]  pat      = 5'b01001;
    logic [17:0] held     = '0;
    logic [17:0] want;
    push_expected();
    img_in    = ref_img;
    img_valid = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = hold_start;
    check("start_latency", {30'd0, data_valid, busy}, 32'd3);
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      data_ready = stall ? pat[cyc % 5] : 1'b1;
      abort      = (hs == abort_at) && data_valid && data_ready;
      if (hs == mutate_at) img_in = '1;
      @(negedge clk);
      if (abort) begin
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("abort_count", hs, abort_at);
        check("abort_idle", {data_valid, busy, done, read_addr}, 32'd0);
        finished = 1'b1;
      end else if (done) begin
        check("done_after_last", {31'd0, prev_hs}, 32'd1);
        check("done_idle", {30'd0, data_valid, busy}, 32'd0);
        check("beat_count", hs, BEATS);
        check("sb_empty", sb.size(), 32'd0);
        if (!stall) check("no_bubble", cyc, BEATS);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("done_pulse", {done, busy, data_valid, read_addr}, 32'd0);
        finished = 1'b1;
      end else begin
        prev_hs = 1'b0;
        check("valid_while_busy", {31'd0, data_valid}, 32'd1);
        if (data_valid) begin
          if (stalled) check("stall_hold", {data_out, read_addr}, held);
          stalled = !data_ready;
          held    = {data_out, read_addr};
          if (data_ready) begin
            if (sb.size() == 0) begin
              check("sb_underflow", 32'd1, 32'd0);
            end else begin
              want = sb.pop_front();
              check($sformatf("beat%0d", hs), {data_out, read_addr}, want);
            end
            hs++;
            prev_hs = 1'b1;
          end
        end
      end
    end
    if (!finished) check("timeout", 32'd0, 32'd1);
    sb.delete();
    data_ready = 1'b0;
    img_in     = ref_img;
  endtask

  initial begin
    for (int k = 0; k < NUM_BYTES; k++) ref_img[k*8 +: 8] = 8'(k);

    #2 rst_n = 1'b0;
    #10;
    check("reset_values", {data_out, data_valid, read_addr, busy, done, error}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {30'd0, data_valid, busy}, 32'd0);

    // Full-rate stream, then a stalled stream holding start high throughout (start ignored while busy/done).
    run_stream(1'b0, -1, -1, 1'b0);
    run_stream(1'b1, -1, -1, 1'b1);

    // start without a full buffer.
    @(posedge clk); #1;
    img_valid = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("error_pulse", {28'd0, error, data_valid, busy, done}, 32'd8);
    @(negedge clk);
    check("error_clear", {28'd0, error, data_valid, busy, done}, 32'd0);

    // abort and start together in IDLE: start is dropped.
    @(posedge clk); #1;
    img_valid = 1'b1;
    start     = 1'b1;
    abort     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_beats_start", {29'd0, data_valid, busy, error}, 32'd0);

    // Abort on the 11th handshake, then a clean restart from byte 0.
    run_stream(1'b0, 10, -1, 1'b0);
    run_stream(1'b0, -1, -1, 1'b0);

    // Snapshot: img_in overwritten after four beats must not reach the output.
    run_stream(1'b1, -1, 4, 1'b0);

    // Asynchronous reset after five beats.
    @(posedge clk); #1;
    img_valid  = 1'b1;
    data_ready = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("pre_reset_state", {21'd0, busy, read_addr}, {21'd0, 1'b1, 10'd40});
    rst_n = 1'b0;
    #1;
    check("async_reset", {data_out, data_valid, read_addr, busy, done, error}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_start_after_reset", {30'd0, data_valid, busy}, 32'd0);
    end
    data_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
